// File: rtl/serial_fifo_pkg.sv
// ============================================================================
//  Module   : serial_fifo_pkg
//  Purpose  : Shared serial definitions: default FIFO depth and the TX
//             handshake FSM state encodings.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_fifo_pkg;

    // Each FIFO holds 2**DEFAULT_DEPTH_LOG2 bytes unless overridden.
    localparam int DEFAULT_DEPTH_LOG2 = 4;

    // TX launch FSM states; encodings are fixed so software/debug can read them.
    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_START   = 2'd1,
        TX_WAIT_HI = 2'd2,
        TX_WAIT_LO = 2'd3
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/serial_fifo_sync_fifo.sv
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with synchronous write and first-word
//             fall-through read. Exposes full, empty and occupancy count.
//             A push into a full FIFO is accepted only when a pop happens
//             in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo
    import serial_fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int                    DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    // Head is forced to zero while empty so the read port has a defined value
    // straight out of reset (storage itself is not reset).
    assign rdata   = empty ? '0 : mem[rptr];

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

`default_nettype wire

// File: rtl/serial_fifo.sv
// ============================================================================
//  Module   : serial_fifo
//  Purpose  : Byte buffering between the UART bit engines and serial_ctrl.
//             RX FIFO with sticky overrun flag, TX FIFO with an autonomous
//             start/busy handshake towards the transmitter.
//  Options  : SERIAL_OVERRUN_CNT_EN - when defined, ovCount_o is a saturating
//             8-bit dropped-byte counter; otherwise it is tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_fifo
    import serial_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // RX side
    input  logic                  rxdReady_i,
    input  logic [7:0]            rxdData_i,
    output logic                  rxValid_o,
    output logic [7:0]            rxData_o,
    input  logic                  rxPop_i,
    output logic [DEPTH_LOG2:0]   rxCount_o,
    output logic                  overrun_o,
    output logic [7:0]            ovCount_o,
    input  logic                  ovClr_i,
    // TX side
    input  logic                  txPush_i,
    input  logic [7:0]            txData_i,
    output logic                  txFull_o,
    output logic                  txIdle_o,
    input  logic                  txdBusy_i,
    output logic                  txdStart_o,
    output logic [7:0]            txdData_o
);

    logic                  rx_full;
    logic                  rx_empty;
    logic                  overrun_event;

    logic                  tx_empty;
    logic [7:0]            tx_head;
    logic [DEPTH_LOG2:0]   tx_count;
    logic                  tx_pop;
    logic                  tx_load;
    tx_state_t             state;
    tx_state_t             state_next;

    // ------------------------------------------------------------------ RX
    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rxdReady_i),
        .wdata (rxdData_i),
        .pop   (rxPop_i),
        .rdata (rxData_o),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rxCount_o)
    );

    assign rxValid_o = !rx_empty;

    // A byte is lost only when full and the head is not leaving this cycle.
    assign overrun_event = rxdReady_i && rx_full && !rxPop_i;

    // Sticky overrun flag; a coincident drop beats the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_o <= 1'b0;
        end else if (overrun_event) begin
            overrun_o <= 1'b1;
        end else if (ovClr_i) begin
            overrun_o <= 1'b0;
        end
    end

`ifdef SERIAL_OVERRUN_CNT_EN
    logic [7:0] ov_count;

    // Saturating dropped-byte counter; a clear coincident with a drop lands on 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_count <= 8'd0;
        end else if (overrun_event) begin
            if (ovClr_i) begin
                ov_count <= 8'd1;
            end else if (ov_count != 8'hFF) begin
                ov_count <= ov_count + 8'd1;
            end
        end else if (ovClr_i) begin
            ov_count <= 8'd0;
        end
    end

    assign ovCount_o = ov_count;
`else
    assign ovCount_o = 8'd0;
`endif

    // ------------------------------------------------------------------ TX
    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (txPush_i),
        .wdata (txData_i),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (txFull_o),
        .empty (tx_empty),
        .count (tx_count)
    );

    assign txIdle_o   = (tx_count == '0) && (state == TX_IDLE);
    assign txdStart_o = (state == TX_START);

    // TX FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // TX FSM next state: launch a byte, pulse start, then track busy high/low.
    always_comb begin
        state_next = state;
        tx_pop     = 1'b0;
        tx_load    = 1'b0;
        case (state)
            TX_IDLE: begin
                if (!tx_empty && !txdBusy_i) begin
                    tx_load    = 1'b1;
                    tx_pop     = 1'b1;
                    state_next = TX_START;
                end
            end
            TX_START:   state_next = TX_WAIT_HI;
            TX_WAIT_HI: if (txdBusy_i)  state_next = TX_WAIT_LO;
            TX_WAIT_LO: if (!txdBusy_i) state_next = TX_IDLE;
            default:    state_next = TX_IDLE;
        endcase
    end

    // Transmit byte register; held until the next launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txdData_o <= 8'd0;
        end else if (tx_load) begin
            txdData_o <= tx_head;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_fifo.sv
`timescale 1ns/1ps

module tb_serial_fifo;

    localparam int DEPTH = 16;
`ifdef SERIAL_OVERRUN_CNT_EN
    localparam int OV1   = 1;
    localparam int OV255 = 255;
`else
    localparam int OV1   = 0;
    localparam int OV255 = 0;
`endif

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       rxdReady_i = 1'b0;
    logic [7:0] rxdData_i = 8'd0;
    logic       rxPop_i   = 1'b0;
    logic       ovClr_i   = 1'b0;
    logic       txPush_i  = 1'b0;
    logic [7:0] txData_i  = 8'd0;
    logic       txdBusy_i = 1'b0;

    logic       rxValid_o;
    logic [7:0] rxData_o;
    logic [4:0] rxCount_o;
    logic       overrun_o;
    logic [7:0] ovCount_o;
    logic       txFull_o;
    logic       txIdle_o;
    logic       txdStart_o;
    logic [7:0] txdData_o;

    serial_fifo #(.DEPTH_LOG2(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxdReady_i (rxdReady_i),
        .rxdData_i  (rxdData_i),
        .rxValid_o  (rxValid_o),
        .rxData_o   (rxData_o),
        .rxPop_i    (rxPop_i),
        .rxCount_o  (rxCount_o),
        .overrun_o  (overrun_o),
        .ovCount_o  (ovCount_o),
        .ovClr_i    (ovClr_i),
        .txPush_i   (txPush_i),
        .txData_i   (txData_i),
        .txFull_o   (txFull_o),
        .txIdle_o   (txIdle_o),
        .txdBusy_i  (txdBusy_i),
        .txdStart_o (txdStart_o),
        .txdData_o  (txdData_o)
    );

    // 25 MHz
    always #20 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] rx_q[$];
    logic [7:0] tx_exp[$];
    int         m_ov    = 0;
    int         m_ovcnt = 0;

    // Monitor / transmitter-model bookkeeping
    int         cyc = 0;
    int         n_starts = 0;
    int         last_busy_cyc = -100;
    logic       prev_start = 1'b0;
    logic       have_last = 1'b0;
    logic [7:0] last_tx = 8'd0;
    logic       start_seen = 1'b0;
    int         busy_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One stimulus cycle; inputs return to idle afterwards.
    task automatic step(input logic rdy, input logic [7:0] d, input logic pop,
                        input logic clr, input logic tpush, input logic [7:0] td);
        rxdReady_i = rdy;
        rxdData_i  = d;
        rxPop_i    = pop;
        ovClr_i    = clr;
        txPush_i   = tpush;
        txData_i   = td;
        if (tpush) tx_exp.push_back(td);
        @(posedge clk); #1;
        rxdReady_i = 1'b0;
        rxPop_i    = 1'b0;
        ovClr_i    = 1'b0;
        txPush_i   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor + reference model, evaluated mid-cycle on the falling edge.
    initial begin
        logic ev;
        logic pop_ok;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                rx_q.delete();
                tx_exp.delete();
                m_ov       = 0;
                m_ovcnt    = 0;
                prev_start = 1'b0;
                have_last  = 1'b0;
                continue;
            end
            // RX outputs against the model
            check("rx_count", 32'(rxCount_o), 32'(rx_q.size()));
            check("rx_valid", 32'(rxValid_o), 32'(rx_q.size() != 0));
            check("overrun",  32'(overrun_o), 32'(m_ov));
            check("ov_count", 32'(ovCount_o), 32'(m_ovcnt));
            if (rx_q.size() != 0) check("rx_data", 32'(rxData_o), 32'(rx_q[0]));

            // TX side: start pulses, launched data, hold and spacing
            if (txdStart_o) begin
                n_starts++;
                check("start_single", 32'(prev_start), 32'd0);
                check("start_gap_ok", 32'((cyc - last_busy_cyc) >= 3), 32'd1);
                if (tx_exp.size() == 0) begin
                    check("start_unexpected", 32'(txdStart_o), 32'd0);
                end else begin
                    last_tx = tx_exp.pop_front();
                    check("txd_data", 32'(txdData_o), 32'(last_tx));
                end
                have_last  = 1'b1;
                start_seen = 1'b1;
            end else if (have_last) begin
                check("txd_hold", 32'(txdData_o), 32'(last_tx));
            end
            prev_start = txdStart_o;
            if (txdBusy_i) last_busy_cyc = cyc;

            // RX model update for the coming clock edge
            pop_ok = rxPop_i && (rx_q.size() != 0);
            ev     = rxdReady_i && (rx_q.size() == DEPTH) && !rxPop_i;
            if (pop_ok) void'(rx_q.pop_front());
            if (rxdReady_i && !ev) rx_q.push_back(rxdData_i);
            if (ev) begin
                m_ov = 1;
`ifdef SERIAL_OVERRUN_CNT_EN
                if (ovClr_i) m_ovcnt = 1;
                else if (m_ovcnt < 255) m_ovcnt++;
`endif
            end else if (ovClr_i) begin
                m_ov    = 0;
                m_ovcnt = 0;
            end
        end
    end

    // Transmitter model: busy rises one cycle after start, lasts 10 cycles.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                busy_cnt   = 0;
                start_seen = 1'b0;
            end else if (start_seen) begin
                busy_cnt   = 10;
                start_seen = 1'b0;
            end
            txdBusy_i = (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int base;
        int w;
        logic done;

        // ---- reset values
        idle(3);
        check("rst_rx_valid", 32'(rxValid_o),  32'd0);
        check("rst_rx_data",  32'(rxData_o),   32'd0);
        check("rst_rx_count", 32'(rxCount_o),  32'd0);
        check("rst_overrun",  32'(overrun_o),  32'd0);
        check("rst_ov_count", 32'(ovCount_o),  32'd0);
        check("rst_tx_full",  32'(txFull_o),   32'd0);
        check("rst_tx_idle",  32'(txIdle_o),   32'd1);
        check("rst_txd_start",32'(txdStart_o), 32'd0);
        check("rst_txd_data", 32'(txdData_o),  32'd0);
        rst_n = 1'b1;
        idle(2);

        // ---- three bytes, fall-through, pops
        step(1, 8'h41, 0, 0, 0, 0);
        check("rx_lat_valid", 32'(rxValid_o), 32'd1);
        step(1, 8'h42, 0, 0, 0, 0);
        step(1, 8'h43, 0, 0, 0, 0);
        check("abc_count", 32'(rxCount_o), 32'd3);
        check("abc_head",  32'(rxData_o),  32'h41);
        step(0, 0, 1, 0, 0, 0);
        check("abc_pop1",  32'(rxData_o),  32'h42);
        step(0, 0, 1, 0, 0, 0);
        check("abc_pop2",  32'(rxData_o),  32'h43);
        step(0, 0, 1, 0, 0, 0);
        check("abc_empty", 32'(rxValid_o), 32'd0);
        step(0, 0, 1, 0, 0, 0);   // pop while empty is ignored
        check("abc_pop_empty_count", 32'(rxCount_o), 32'd0);

        // ---- 17 bytes into a 16-deep FIFO
        for (int i = 1; i <= 17; i++) step(1, 8'(i), 0, 0, 0, 0);
        check("full_count",    32'(rxCount_o), 32'd16);
        check("full_overrun",  32'(overrun_o), 32'd1);
        check("full_ov_count", 32'(ovCount_o), 32'(OV1));
        step(0, 0, 0, 1, 0, 0);
        check("clr_overrun",   32'(overrun_o), 32'd0);
        check("clr_ov_count",  32'(ovCount_o), 32'd0);
        // full + push + pop in the same cycle
        step(1, 8'h55, 1, 0, 0, 0);
        check("fullpp_count",   32'(rxCount_o), 32'd16);
        check("fullpp_overrun", 32'(overrun_o), 32'd0);
        for (int i = 2; i <= 16; i++) begin
            check("drain_order", 32'(rxData_o), 32'(i));
            step(0, 0, 1, 0, 0, 0);
        end
        check("drain_last", 32'(rxData_o), 32'h55);
        step(0, 0, 1, 0, 0, 0);
        check("drain_empty", 32'(rxValid_o), 32'd0);

        // ---- overrun coincident with clear, then saturation
        for (int i = 0; i < 16; i++) step(1, 8'(8'h80 + i), 0, 0, 0, 0);
        step(1, 8'hEE, 0, 1, 0, 0);
        check("coinc_overrun",  32'(overrun_o), 32'd1);
        check("coinc_ov_count", 32'(ovCount_o), 32'(OV1));
        step(0, 0, 0, 1, 0, 0);
        check("later_clr_overrun",  32'(overrun_o), 32'd0);
        check("later_clr_ov_count", 32'(ovCount_o), 32'd0);
        for (int i = 0; i < 260; i++) step(1, 8'(i), 0, 0, 0, 0);
        check("sat_ov_count", 32'(ovCount_o), 32'(OV255));
        check("sat_overrun",  32'(overrun_o), 32'd1);
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0, 0);
        check("sat_drained", 32'(rxValid_o), 32'd0);

        // ---- randomized RX traffic (fill-biased then drain-biased)
        for (int i = 0; i < 500; i++) begin
            logic rdy, pop, clr;
            if (i < 250) begin
                rdy = ($urandom_range(0, 3) != 0);
                pop = ($urandom_range(0, 3) == 0);
            end else begin
                rdy = ($urandom_range(0, 3) == 0);
                pop = ($urandom_range(0, 3) != 0);
            end
            clr = ($urandom_range(0, 15) == 0);
            step(rdy, 8'($urandom), pop, clr, 0, 0);
        end
        for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0, 0);
        check("rand_rx_empty", 32'(rxValid_o), 32'd0);

        // ---- TX: two bytes, latency and handshake
        base = n_starts;
        txPush_i = 1'b1; txData_i = 8'hA5; tx_exp.push_back(8'hA5);
        @(posedge clk); #1;
        txData_i = 8'h5A; tx_exp.push_back(8'h5A);
        @(negedge clk);
        check("tx_lat_n1", 32'(txdStart_o), 32'd0);
        @(posedge clk); #1;
        txPush_i = 1'b0;
        @(negedge clk);
        check("tx_lat_n2",      32'(txdStart_o), 32'd1);
        check("tx_lat_n2_data", 32'(txdData_o),  32'hA5);
        @(posedge clk); #1;
        w = 0;
        done = 1'b0;
        while (!done && w < 300) begin
            done = (n_starts == base + 2) && txIdle_o && !txdBusy_i;
            if (!done) begin @(posedge clk); #1; end
            w++;
        end
        check("tx2_done",   32'(done),              32'd1);
        check("tx2_starts", 32'(n_starts - base),   32'd2);
        check("tx2_idle",   32'(txIdle_o),          32'd1);

        // ---- TX: randomized bytes and gaps
        base = n_starts;
        for (int i = 0; i < 10; i++) begin
            idle($urandom_range(0, 12));
            step(0, 0, 0, 0, 1, 8'($urandom));
        end
        w = 0;
        done = 1'b0;
        while (!done && w < 400) begin
            done = (n_starts == base + 10) && txIdle_o && !txdBusy_i;
            if (!done) begin @(posedge clk); #1; end
            w++;
        end
        check("txr_done",   32'(done),            32'd1);
        check("txr_starts", 32'(n_starts - base), 32'd10);

        // ---- reset while in WAIT_LO with five bytes still queued
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 8'(8'h30 + i));
        w = 0;
        while (!txdBusy_i && w < 50) begin @(posedge clk); #1; w++; end
        check("wlo_busy_seen", 32'(txdBusy_i), 32'd1);
        idle(3);
        #5 rst_n = 1'b0;
        #1;
        check("rstmid_start",   32'(txdStart_o), 32'd0);
        check("rstmid_idle",    32'(txIdle_o),   32'd1);
        check("rstmid_full",    32'(txFull_o),   32'd0);
        check("rstmid_data",    32'(txdData_o),  32'd0);
        idle(2);
        rst_n = 1'b1;
        base = n_starts;
        idle(30);
        check("post_rst_starts", 32'(n_starts - base), 32'd0);
        check("post_rst_idle",   32'(txIdle_o),        32'd1);
        check("post_rst_full",   32'(txFull_o),        32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
